// File: rtl/spi_dac_pkg.sv
// Shared types and helpers for the SPI DAC frame writer.
// Optional feature macro used by the top: SPI_DAC_PD_MODE_EN (power-down control bits).
package spi_dac_pkg;

    // Width of the FSM state encoding.
    localparam int unsigned STATE_W = 3;

    // Upper bound on a single frame width supported by the mask helper.
    localparam int unsigned MASK_MAX_W = 64;

    // Transaction sequencing: IDLE -> SETUP -> SHIFT_HI <-> SHIFT_LO -> END -> GAP -> IDLE.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_SHIFT_HI = 3'd2,
        ST_SHIFT_LO = 3'd3,
        ST_END      = 3'd4,
        ST_GAP      = 3'd5
    } dac_state_e;

    // Mask keeping only the data_w code LSBs of a frame; callers truncate to FRAME_W.
    function automatic logic [MASK_MAX_W-1:0] frame_mask(input int unsigned data_w);
        logic [MASK_MAX_W-1:0] m;
        m = '0;
        for (int unsigned b = 0; b < MASK_MAX_W; b++) begin
            if (b < data_w) begin
                m[b] = 1'b1;
            end
        end
        return m;
    endfunction

    // Total serial bits per transaction for num_ch chained frames.
    function automatic int unsigned total_bits(input int unsigned num_ch,
                                               input int unsigned frame_w);
        return num_ch * frame_w;
    endfunction

endpackage

// File: rtl/spi_dac_bit_timer.sv
// SCLK half-period timer for the SPI DAC frame writer.
// TICK is high in the last CLK cycle of each CLK_DIV-cycle half period.
// RELOAD restarts the count so the first half period after it is full length.
module spi_dac_bit_timer #(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic RELOAD,
    output logic TICK
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    // Down-counter: reload while held or on terminal count, otherwise decrement.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            div_cnt <= '0;
        end else if (RELOAD || (div_cnt == '0)) begin
            div_cnt <= DIV_LOAD;
        end else begin
            div_cnt <= div_cnt - 1'b1;
        end
    end

    assign TICK = (div_cnt == '0);

endmodule

// File: rtl/spi_dac_frame_writer.sv
// Serial DAC write engine: shifts NUM_CH daisy-chained FRAME_W-bit frames
// MSB-first (highest channel first) under one chip select, SCLK idle low,
// CLK_DIV CLK cycles per SCLK half period, CS held high CS_GAP cycles
// (END inclusive) before OVER re-asserts. DONE pulses on the END cycle.
// Optional feature macro: SPI_DAC_PD_MODE_EN adds the PD input whose two bits
// per frame fill control bits DATA_W+1..DATA_W; otherwise all control bits are 0.
module spi_dac_frame_writer
    import spi_dac_pkg::*;
#(
    parameter int unsigned FRAME_W = 24,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned NUM_CH  = 1,
    parameter int unsigned CLK_DIV = 1,
    parameter int unsigned CS_GAP  = 2
) (
    input  logic                        CLK,
    input  logic                        RESET_N,
    input  logic                        TR,
    input  logic [NUM_CH*FRAME_W-1:0]   DATA,
`ifdef SPI_DAC_PD_MODE_EN
    input  logic [NUM_CH*2-1:0]         PD,
`endif
    output logic                        DA_CS,
    output logic                        DA_SCLK,
    output logic                        DA_SDO,
    output logic                        OVER,
    output logic                        DONE
);

    localparam int unsigned N        = total_bits(NUM_CH, FRAME_W);
    localparam int unsigned BCNT_W   = $clog2(N + 1);
    localparam int unsigned GAP_W    = $clog2(CS_GAP + 1);
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(N - 1);
    // END already accounts for one of the CS_GAP high cycles; GAP covers the rest.
    localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'((CS_GAP > 1) ? (CS_GAP - 2) : 0);
    localparam logic [FRAME_W-1:0] FRAME_MASK = FRAME_W'(frame_mask(DATA_W));

    // Elaboration-time parameter range guards.
    if (FRAME_W < DATA_W + 2) begin : g_bad_frame_w
        $error("spi_dac_frame_writer: FRAME_W must be >= DATA_W+2");
    end
    if (FRAME_W > MASK_MAX_W) begin : g_bad_frame_max
        $error("spi_dac_frame_writer: FRAME_W exceeds supported maximum");
    end
    if ((NUM_CH < 1) || (NUM_CH > 8)) begin : g_bad_num_ch
        $error("spi_dac_frame_writer: NUM_CH must be 1..8");
    end
    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("spi_dac_frame_writer: CLK_DIV must be >= 1");
    end
    if (CS_GAP < 1) begin : g_bad_cs_gap
        $error("spi_dac_frame_writer: CS_GAP must be >= 1");
    end

    dac_state_e          state;
    logic [N-1:0]        shreg;
    logic [N-1:0]        load_word;
    logic [BCNT_W-1:0]   bit_cnt;
    logic [GAP_W-1:0]    gap_cnt;
    logic                tick;
    logic                timer_reload;

    // Build the shift-register load image: code LSBs kept, control bits forced (or PD).
    always_comb begin
        load_word = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            load_word[k*FRAME_W +: FRAME_W] = DATA[k*FRAME_W +: FRAME_W] & FRAME_MASK;
`ifdef SPI_DAC_PD_MODE_EN
            load_word[k*FRAME_W + DATA_W +: 2] = PD[2*k +: 2];
`endif
        end
    end

    // Half-period timing restarts whenever the FSM is outside the shift phases.
    assign timer_reload = (state != ST_SHIFT_HI) && (state != ST_SHIFT_LO);

    spi_dac_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_timer (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .RELOAD  (timer_reload),
        .TICK    (tick)
    );

    // Transaction FSM with registered pin outputs, set on entry to each state.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            DA_CS   <= 1'b1;
            DA_SCLK <= 1'b0;
            DA_SDO  <= 1'b0;
            OVER    <= 1'b1;
            DONE    <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (TR) begin
                        shreg   <= load_word;
                        bit_cnt <= '0;
                        state   <= ST_SETUP;
                        DA_CS   <= 1'b0;
                        OVER    <= 1'b0;
                        DA_SCLK <= 1'b0;
                        DA_SDO  <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    state   <= ST_SHIFT_HI;
                    DA_SCLK <= 1'b1;
                    DA_SDO  <= shreg[N-1];
                end
                ST_SHIFT_HI: begin
                    if (tick) begin
                        state   <= ST_SHIFT_LO;
                        DA_SCLK <= 1'b0;
                    end
                end
                ST_SHIFT_LO: begin
                    if (tick) begin
                        // SDO for the next bit is taken from shreg[N-2], i.e. the
                        // MSB after this cycle's left shift lands.
                        shreg   <= {shreg[N-2:0], 1'b0};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state  <= ST_END;
                            DA_CS  <= 1'b1;
                            DA_SDO <= 1'b0;
                            DONE   <= 1'b1;
                        end else begin
                            state   <= ST_SHIFT_HI;
                            DA_SCLK <= 1'b1;
                            DA_SDO  <= shreg[N-2];
                        end
                    end
                end
                ST_END: begin
                    if (CS_GAP > 1) begin
                        state   <= ST_GAP;
                        gap_cnt <= GAP_LOAD;
                    end else begin
                        state <= ST_IDLE;
                        OVER  <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= ST_IDLE;
                        OVER  <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    DA_CS   <= 1'b1;
                    DA_SCLK <= 1'b0;
                    DA_SDO  <= 1'b0;
                    OVER    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_dac_frame_writer.sv
// Self-checking bench for spi_dac_frame_writer: three instances with different
// parameters, a timing-rule model compared every cycle, and literal checks.
module tb_spi_dac_frame_writer;

`ifdef SPI_DAC_PD_MODE_EN
    localparam bit PD_ON = 1'b1;
`else
    localparam bit PD_ON = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        trv [3] = '{1'b0, 1'b0, 1'b0};
    logic [23:0] data0 = '0;
    logic [23:0] data1 = '0;
    logic [47:0] data2 = '0;
    logic        ocs [3];
    logic        osclk [3];
    logic        osdo [3];
    logic        oover [3];
    logic        odone [3];
    logic [63:0] raw_in [3];
    logic [7:0]  pd_in [3];
`ifdef SPI_DAC_PD_MODE_EN
    logic [1:0]  pd0 = '0;
    logic [1:0]  pd1 = '0;
    logic [3:0]  pd2 = '0;
`endif

    int p_div [3] = '{1, 3, 1};
    int p_n   [3] = '{24, 24, 48};
    int p_gap [3] = '{2, 2, 3};
    int p_nch [3] = '{1, 1, 2};

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    assign raw_in[0] = 64'(data0);
    assign raw_in[1] = 64'(data1);
    assign raw_in[2] = 64'(data2);
`ifdef SPI_DAC_PD_MODE_EN
    assign pd_in[0] = 8'(pd0);
    assign pd_in[1] = 8'(pd1);
    assign pd_in[2] = 8'(pd2);
`else
    assign pd_in[0] = '0;
    assign pd_in[1] = '0;
    assign pd_in[2] = '0;
`endif

    spi_dac_frame_writer #(.FRAME_W(24), .DATA_W(16), .NUM_CH(1), .CLK_DIV(1), .CS_GAP(2)) u_dut0 (
        .CLK(CLK), .RESET_N(RESET_N), .TR(trv[0]), .DATA(data0),
`ifdef SPI_DAC_PD_MODE_EN
        .PD(pd0),
`endif
        .DA_CS(ocs[0]), .DA_SCLK(osclk[0]), .DA_SDO(osdo[0]), .OVER(oover[0]), .DONE(odone[0]));

    spi_dac_frame_writer #(.FRAME_W(24), .DATA_W(16), .NUM_CH(1), .CLK_DIV(3), .CS_GAP(2)) u_dut1 (
        .CLK(CLK), .RESET_N(RESET_N), .TR(trv[1]), .DATA(data1),
`ifdef SPI_DAC_PD_MODE_EN
        .PD(pd1),
`endif
        .DA_CS(ocs[1]), .DA_SCLK(osclk[1]), .DA_SDO(osdo[1]), .OVER(oover[1]), .DONE(odone[1]));

    spi_dac_frame_writer #(.FRAME_W(24), .DATA_W(16), .NUM_CH(2), .CLK_DIV(1), .CS_GAP(3)) u_dut2 (
        .CLK(CLK), .RESET_N(RESET_N), .TR(trv[2]), .DATA(data2),
`ifdef SPI_DAC_PD_MODE_EN
        .PD(pd2),
`endif
        .DA_CS(ocs[2]), .DA_SCLK(osclk[2]), .DA_SDO(osdo[2]), .OVER(oover[2]), .DONE(odone[2]));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- model: transaction timeline from the start cycle ----------------
    logic        act [3] = '{1'b0, 1'b0, 1'b0};
    int          d [3];
    logic [63:0] word [3];

    function automatic logic [63:0] expect_word(logic [63:0] raw, int nch, logic [7:0] pd);
        logic [63:0] w;
        w = '0;
        for (int ch = 0; ch < nch; ch++) begin
            w[ch*24 +: 16] = raw[ch*24 +: 16];
            if (PD_ON) w[ch*24 + 16 +: 2] = pd[ch*2 +: 2];
        end
        return w;
    endfunction

    always @(posedge CLK or negedge RESET_N) begin
        for (int i = 0; i < 3; i++) begin
            if (!RESET_N) begin
                act[i] <= 1'b0;
            end else if (act[i]) begin
                d[i] <= d[i] + 1;
                if (d[i] + 1 >= 2 + 2 * p_div[i] * p_n[i] + p_gap[i]) act[i] <= 1'b0;
            end else if (trv[i]) begin
                act[i]  <= 1'b1;
                d[i]    <= 1;
                word[i] <= expect_word(raw_in[i], p_nch[i], pd_in[i]);
            end
        end
    end

    // {CS, SCLK, SDO, OVER, DONE} expected for the current cycle
    function automatic logic [4:0] exp_out(int i);
        int e, k, h;
        if (!act[i]) return 5'b10010;
        e = 2 + 2 * p_div[i] * p_n[i];
        h = p_div[i];
        if (d[i] == 1) return 5'b00000;
        if (d[i] < e) begin
            k = d[i] - 2;
            return {1'b0, ((k % (2 * h)) < h), word[i][p_n[i] - 1 - k / (2 * h)], 1'b0, 1'b0};
        end
        if (d[i] == e) return 5'b10001;
        return 5'b10000;
    endfunction

    always @(negedge CLK) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("dut%0d_pins{CS,SCLK,SDO,OVER,DONE}", i),
                64'({ocs[i], osclk[i], osdo[i], oover[i], odone[i]}), 64'(exp_out(i)));
        end
    end

    // ---------------- observation monitor for the literal checks ----------------
    logic        prev_cs [3] = '{1'b1, 1'b1, 1'b1};
    logic        prev_sclk [3] = '{1'b0, 1'b0, 1'b0};
    logic        prev_over [3] = '{1'b1, 1'b1, 1'b1};
    logic        seen_hi [3];
    logic [63:0] m_stream [3];
    int m_bits [3], m_dones [3] = '{0, 0, 0}, m_done_cyc [3], m_over_cyc [3];
    int m_rise_cyc [3], m_fall_cyc [3], m_prev_fall [3], m_falls [3] = '{0, 0, 0};
    int hrun [3], lrun [3], hmin [3], hmax [3], lmin [3], lmax [3];

    always @(negedge CLK) begin
        for (int i = 0; i < 3; i++) begin
            prev_cs[i]   <= ocs[i];
            prev_sclk[i] <= osclk[i];
            prev_over[i] <= oover[i];
            if (odone[i]) begin
                m_dones[i]    <= m_dones[i] + 1;
                m_done_cyc[i] <= cyc;
            end
            if (!prev_over[i] && oover[i]) m_over_cyc[i] <= cyc;
            if (!prev_cs[i] && ocs[i]) m_rise_cyc[i] <= cyc;
            if (prev_cs[i] && !ocs[i]) begin
                m_falls[i]     <= m_falls[i] + 1;
                m_prev_fall[i] <= m_fall_cyc[i];
                m_fall_cyc[i]  <= cyc;
                m_stream[i]    <= '0;
                m_bits[i]      <= 0;
                hmin[i] <= 1000; hmax[i] <= 0; lmin[i] <= 1000; lmax[i] <= 0;
                hrun[i] <= 0; lrun[i] <= 0; seen_hi[i] <= 1'b0;
            end else if (!ocs[i]) begin
                if (osclk[i] && !prev_sclk[i]) begin
                    m_stream[i] <= {m_stream[i][62:0], osdo[i]};
                    m_bits[i]   <= m_bits[i] + 1;
                    hrun[i]     <= 1;
                    seen_hi[i]  <= 1'b1;
                    if (seen_hi[i]) begin
                        if (lrun[i] < lmin[i]) lmin[i] <= lrun[i];
                        if (lrun[i] > lmax[i]) lmax[i] <= lrun[i];
                    end
                end else if (osclk[i]) begin
                    hrun[i] <= hrun[i] + 1;
                end else if (prev_sclk[i]) begin
                    if (hrun[i] < hmin[i]) hmin[i] <= hrun[i];
                    if (hrun[i] > hmax[i]) hmax[i] <= hrun[i];
                    lrun[i] <= 1;
                end else if (seen_hi[i]) begin
                    lrun[i] <= lrun[i] + 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (!(oover[0] && oover[1] && oover[2]) && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_idle_within_budget"}, 64'({oover[0], oover[1], oover[2]}), 64'(3'b111));
        repeat (2) tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int t0, f0, dn0;

    initial begin
        RESET_N = 1'b0;
        repeat (3) tick();
        chk("reset_pins0{CS,SCLK,SDO,OVER,DONE}",
            64'({ocs[0], osclk[0], osdo[0], oover[0], odone[0]}), 64'(5'b10010));
        RESET_N = 1'b1;
        tick();

        // A: one transaction on each instance; DATA changes after t0 are ignored
        data0 = 24'hFF_ABCD;
        data1 = 24'h00_8001;
        data2 = {24'h00_1234, 24'h00_5678};
        trv[0] = 1'b1; trv[1] = 1'b1; trv[2] = 1'b1;
        t0 = cyc;
        tick();
        trv[0] = 1'b0; trv[1] = 1'b0; trv[2] = 1'b0;
        data0 = 24'h55_5555;
        data1 = 24'hFF_FFFF;
        wait_idle(300, "A");
        chk("A_dut0_stream", m_stream[0], 64'h00ABCD);
        chk("A_dut0_bits", 64'(m_bits[0]), 64'd24);
        chk("A_dut0_cs_fall", 64'(m_fall_cyc[0]), 64'(t0 + 1));
        chk("A_dut0_cs_rise", 64'(m_rise_cyc[0]), 64'(t0 + 50));
        chk("A_dut0_done", 64'(m_done_cyc[0]), 64'(t0 + 50));
        chk("A_dut0_over", 64'(m_over_cyc[0]), 64'(t0 + 52));
        chk("A_dut1_stream", m_stream[1], 64'h008001);
        chk("A_dut1_done", 64'(m_done_cyc[1]), 64'(t0 + 146));
        chk("A_dut1_hi_len", 64'({hmin[1][15:0], hmax[1][15:0]}), 64'h0003_0003);
        chk("A_dut1_lo_len", 64'({lmin[1][15:0], lmax[1][15:0]}), 64'h0003_0003);
        chk("A_dut2_stream", m_stream[2], 64'h0012_3400_5678);
        chk("A_dut2_bits", 64'(m_bits[2]), 64'd48);
        chk("A_dut2_done", 64'(m_done_cyc[2]), 64'(t0 + 98));
        chk("A_dut2_over", 64'(m_over_cyc[2]), 64'(t0 + 101));

        // B: a TR pulse at t0+10 mid-transfer is ignored and not queued
        f0 = m_falls[0];
        data0 = 24'hA5_1E0F;
        trv[0] = 1'b1;
        t0 = cyc;
        tick();
        trv[0] = 1'b0;
        repeat (9) tick();
        data0 = 24'h00_FFFF;
        trv[0] = 1'b1;
        tick();
        trv[0] = 1'b0;
        wait_idle(200, "B");
        repeat (10) tick();
        chk("B_single_transaction", 64'(m_falls[0] - f0), 64'd1);
        chk("B_stream", m_stream[0], 64'h001E0F);
        chk("B_done", 64'(m_done_cyc[0]), 64'(t0 + 50));

        // C: TR held high gives back-to-back transactions starting when OVER rises
        f0 = m_falls[0];
        data0 = 24'h00_C3C3;
        trv[0] = 1'b1;
        t0 = cyc;
        repeat (60) tick();
        trv[0] = 1'b0;
        wait_idle(200, "C");
        repeat (10) tick();
        chk("C_two_transactions", 64'(m_falls[0] - f0), 64'd2);
        chk("C_first_fall", 64'(m_prev_fall[0]), 64'(t0 + 1));
        chk("C_second_fall", 64'(m_fall_cyc[0]), 64'(t0 + 53));
        chk("C_second_done", 64'(m_done_cyc[0]), 64'(t0 + 102));
        chk("C_stream", m_stream[0], 64'h00C3C3);

        // D: reset during bit 7 aborts at once without DONE; next frame is complete
        dn0 = m_dones[0];
        data0 = 24'h12_3456;
        trv[0] = 1'b1;
        t0 = cyc;
        tick();
        trv[0] = 1'b0;
        repeat (15) tick();
        chk("D_in_bit7_sclk_high", 64'({ocs[0], osclk[0]}), 64'(2'b01));
        #2;
        RESET_N = 1'b0;
        #1;
        chk("D_abort_pins{CS,SCLK,OVER,DONE}",
            64'({ocs[0], osclk[0], oover[0], odone[0]}), 64'(4'b1010));
        repeat (2) tick();
        RESET_N = 1'b1;
        tick();
        chk("D_no_done_on_abort", 64'(m_dones[0] - dn0), 64'd0);
        trv[0] = 1'b1;
        t0 = cyc;
        tick();
        trv[0] = 1'b0;
        wait_idle(200, "D");
        chk("D_stream_after_reset", m_stream[0], 64'h003456);
        chk("D_done_after_reset", 64'(m_done_cyc[0]), 64'(t0 + 50));
        chk("D_one_done", 64'(m_dones[0] - dn0), 64'd1);

        // E: control-bit handling with zero and all-ones code fields
        data0 = 24'h00_0000;
        data1 = 24'hFF_FFFF;
        data2 = {24'hFF_FFFF, 24'hFF_FFFF};
`ifdef SPI_DAC_PD_MODE_EN
        pd0 = 2'b11;
        pd1 = 2'b10;
        pd2 = 4'b0110;
`endif
        trv[0] = 1'b1; trv[1] = 1'b1; trv[2] = 1'b1;
        tick();
        trv[0] = 1'b0; trv[1] = 1'b0; trv[2] = 1'b0;
        wait_idle(300, "E");
`ifdef SPI_DAC_PD_MODE_EN
        chk("E_dut0_pd_stream", m_stream[0], 64'h030000);
        chk("E_dut1_pd_stream", m_stream[1], 64'h02FFFF);
        chk("E_dut2_pd_stream", m_stream[2], 64'h01FF_FF02_FFFF);
`else
        chk("E_dut0_stream", m_stream[0], 64'h000000);
        chk("E_dut1_stream", m_stream[1], 64'h00FFFF);
        chk("E_dut2_stream", m_stream[2], 64'h00FF_FF00_FFFF);
`endif

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
